// File: rtl/enigma_output_formatter.sv
// enigma_output_formatter
//   Turns enciphered letter indices (0..25, A=0) into an ASCII byte stream
//   laid out as GROUP_LEN-letter groups separated by spaces, with an LF after
//   every GROUPS_PER_LINE groups. A small letter FIFO decouples the cipher
//   core from a slow byte sink. in_flush pads the open group with 'X' and
//   terminates the line once all earlier letters have been emitted.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    letter handshake; in_char is the 5-bit index
//   in_flush             end-of-message request
//   out_valid/out_ready  byte handshake; out_byte is the ASCII byte
//   drop                 one-cycle pulse after an invalid index is discarded
//   busy                 letters queued, byte presented, or flush pending
module enigma_output_formatter #(
    parameter int GROUP_LEN       = 5,
    parameter int GROUPS_PER_LINE = 10,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_char,
    input  logic       in_flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       drop,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] GL  = 4'(GROUP_LEN);
    localparam logic [4:0] GPL = 5'(GROUPS_PER_LINE);

    // State names the byte currently presented on out_byte; IDLE = none.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LETTER,
        S_SEP,
        S_PAD,
        S_EOL
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      letter_cnt_q, letter_cnt_d;
    logic [3:0]      group_cnt_q, group_cnt_d;
    logic            flush_q, flush_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_byte_q, out_byte_d;
    logic            drop_q, drop_d;

    logic [4:0]      mem_q [FIFO_DEPTH];
    logic [4:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            pop;
    logic            push;
    logic            bad;
    logic            flush_set;
    logic            pick;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign in_ready  = (count_q != CW'(FIFO_DEPTH)) || pop;
    assign push      = in_valid && in_ready && (in_char < 5'd26);
    assign bad       = in_valid && in_ready && (in_char >= 5'd26);
    // Flush is ignored while a letter offered with it is being stalled.
    assign flush_set = in_flush && (!in_valid || in_ready);

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign drop      = drop_q;
    assign busy      = (count_q != '0) || out_valid_q || flush_q;

    // Output sequencer. Whenever the output slot frees up (IDLE, or the
    // presented byte is accepted) the next byte is chosen in the same cycle,
    // which keeps the stream at one byte per clock.
    always_comb begin
        state_d      = state_q;
        letter_cnt_d = letter_cnt_q;
        group_cnt_d  = group_cnt_q;
        flush_d      = flush_q;
        out_byte_d   = out_byte_q;
        pop          = 1'b0;
        pick         = 1'b0;

        unique case (state_q)
            S_IDLE: pick = 1'b1;
            S_LETTER: begin
                if (out_ready) begin
                    letter_cnt_d = letter_cnt_q + 4'd1;
                    pick         = 1'b1;
                end
            end
            S_SEP: begin
                if (out_ready) begin
                    letter_cnt_d = 4'd0;
                    if ({1'b0, group_cnt_q} + 5'd1 == GPL) group_cnt_d = 4'd0;
                    else                                  group_cnt_d = group_cnt_q + 4'd1;
                    pick = 1'b1;
                end
            end
            S_PAD: begin
                if (out_ready) begin
                    letter_cnt_d = letter_cnt_q + 4'd1;
                    if (letter_cnt_q + 4'd1 == GL) begin
                        state_d    = S_EOL;
                        out_byte_d = 8'h0A;
                    end
                end
            end
            S_EOL: begin
                if (out_ready) begin
                    letter_cnt_d = 4'd0;
                    group_cnt_d  = 4'd0;
                    flush_d      = 1'b0;
                    pick         = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pick) begin
            if (letter_cnt_d == GL) begin
                // Group complete: space, or LF when this closes the line.
                state_d    = S_SEP;
                out_byte_d = ({1'b0, group_cnt_d} + 5'd1 < GPL) ? 8'h20 : 8'h0A;
            end else if (count_q != '0) begin
                pop        = 1'b1;
                state_d    = S_LETTER;
                out_byte_d = 8'h41 + 8'(mem_q[rd_ptr_q]);
            end else if (flush_d) begin
                if (letter_cnt_d != 4'd0) begin
                    state_d    = S_PAD;
                    out_byte_d = 8'h58;
                end else if (group_cnt_d != 4'd0) begin
                    state_d    = S_EOL;
                    out_byte_d = 8'h0A;
                end else begin
                    // Nothing open on the line: flush is a no-op.
                    flush_d = 1'b0;
                    state_d = S_IDLE;
                end
            end else begin
                state_d = S_IDLE;
            end
        end

        // A new request only takes effect next cycle, after any letter
        // accepted alongside it is already in the FIFO.
        if (flush_set) flush_d = 1'b1;

        out_valid_d = (state_d != S_IDLE);
        drop_d      = bad;
    end

    // Letter FIFO.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_char;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            letter_cnt_q <= 4'd0;
            group_cnt_q  <= 4'd0;
            flush_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'h00;
            drop_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'd0;
        end else begin
            state_q      <= state_d;
            letter_cnt_q <= letter_cnt_d;
            group_cnt_q  <= group_cnt_d;
            flush_q      <= flush_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            drop_q       <= drop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: doc/enigma_output_formatter.md
# enigma_output_formatter

Downstream stage of the Enigma cipher core. Takes enciphered letter indices (0–25, A=0) one per handshake and converts them to an ASCII byte stream in the traditional five-letter group layout. Uppercase letters are separated by spaces, and lines are broken by LF after a fixed number of groups. An internal FIFO decouples the core from a slow byte sink (UART TX / display), and a flush input pads the final group with 'X' and closes the line at end of message.

## Interface
- GROUP_LEN, 5: letters per group, range 1–15.
- GROUPS_PER_LINE, 10: groups per line, range 1–15.
- FIFO_DEPTH, 4: letter FIFO entries; power of two, at least 2.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_char is presented.
- in_ready  output  1  FIFO not full (combinational from FIFO count).
- in_char  input  5  letter index. Values 26–31, including the core's idle code 5'b11111, are invalid.
- in_flush  input  1  end-of-message request; sampled when in_valid=0 or together with an accepted letter.
- out_valid  output  1  out_byte holds a byte for the sink.
- out_ready  input  1  sink accepts out_byte this cycle.
- out_byte  output  8  ASCII byte.
- drop  output  1  one-cycle pulse: an invalid in_char was accepted and discarded.
- busy  output  1  FIFO non-empty, output pending, or flush pending.

## Operation
- Input transfer: in_valid && in_ready at a rising edge.
  - A valid letter (0–25) is written to the FIFO.
  - An invalid letter is consumed (in_ready unchanged), not written, and drop=1 for the next cycle.
- Letter byte: out_byte = 8'h41 + index.
- Counters: letter_cnt (0..GROUP_LEN) and group_cnt (0..GROUPS_PER_LINE-1), both 4 bits, no wrap outside these ranges.
- FSM states: IDLE, LETTER, SEP, PAD, EOL.
  - IDLE: if the FIFO is non-empty, pop the FIFO head into out_byte and go to LETTER. Otherwise, if a flush is pending, go to PAD (letter_cnt>0), EOL (letter_cnt=0, group_cnt>0), or clear the flush and stay in IDLE (both counters 0).
  - LETTER: on out_ready, increment letter_cnt. If letter_cnt reaches GROUP_LEN, go to SEP; else return to IDLE.
  - SEP: present 8'h20 if group_cnt+1 < GROUPS_PER_LINE, else 8'h0A. On out_ready, clear letter_cnt, advance group_cnt (wrap to 0 on LF), and go to IDLE.
  - PAD: present 8'h58 ('X') repeatedly, incrementing letter_cnt on each out_ready until it reaches GROUP_LEN, then go to EOL.
  - EOL: present 8'h0A. On out_ready, clear both counters and the flush-pending flag, and go to IDLE.
- Flush is recorded in flush_pending and acts only once the FIFO is empty, so all earlier letters are emitted first. A letter accepted in the same cycle as in_flush precedes the flush. A second flush while one is pending is merged into it. Letters arriving while the flush is pending queue in the FIFO and are emitted after EOL.
- A separator is emitted immediately after the GROUP_LEN-th letter. A trailing space is therefore normal at end of stream without a flush.

## Timing
- Reset values: out_valid=0, out_byte=8'h00, drop=0, busy=0, FSM=IDLE, FIFO empty, counters 0, flush_pending=0. in_ready=1 as soon as rst_n is low, since the FIFO is empty.
- Reset is asynchronous and takes effect mid-operation: a byte on out_valid is discarded and FIFO contents are lost. The next letter after release starts a fresh group and line.
- Latency: a letter accepted at edge k into an idle, empty formatter gives out_valid=1 after edge k+1.
- out_valid/out_byte are registered and held stable until out_ready=1. No byte is skipped or repeated.
- Throughput with out_ready=1 is one byte per cycle.
  - Separator, pad, and EOL cycles consume output slots, so the FIFO fills and in_ready drops when the input rate exceeds the output rate.
  - Simultaneous FIFO push and pop in one cycle is supported when the FIFO is full, so in_ready stays 1.
- With out_ready held 0: exactly FIFO_DEPTH letters are accepted beyond the one held in out_byte, then in_ready=0.
- busy falls in the cycle after the last byte is accepted with nothing pending.

## Test plan
- Letters 0,1,2,3,4 with out_ready=1 → bytes 41 42 43 44 45 20. No further output; busy returns to 0.
- 50 letters of index 25 with defaults → each group is "ZZZZZ" followed by 20, except the 10th group, which is followed by 0A; group_cnt then restarts.
- Letters 7,8,9 then in_flush pulse → 48 49 4A 58 58 0A. A following letter 0 starts a new group: 41.
- out_ready=0 for 20 cycles while offering 10 letters → exactly FIFO_DEPTH+1 accepted, then in_ready=0, out_byte held at the first letter. On release, all letters arrive in order with no duplicates.
- in_char=31 and in_char=26, each with in_valid=1 → consumed, drop pulses once per invalid letter, no output byte, counters unchanged.
- Reset asserted after 3 letters of a group, mid-handshake with out_valid=1 → out_valid=0 immediately. After release, letters 0–4 produce 41 42 43 44 45 20.
